// File: rtl/bus_responder_pkg.sv
// Shared encodings for the bus responder target.
// FSM state values are visible on rsp_state.
package bus_responder_pkg;

  typedef logic [1:0] rsp_state_t;

  localparam rsp_state_t RSP_IDLE = 2'd0;
  localparam rsp_state_t RSP_WAIT = 2'd1;
  localparam rsp_state_t RSP_ACK  = 2'd2;
  localparam rsp_state_t RSP_DONE = 2'd3;

  localparam int CNT_W = 4;

endpackage

// File: rtl/responder_regfile.sv
// Local storage for the responder.
// Synchronous write port and combinational read port.
module responder_regfile #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rd = mem_q[raddr];

endmodule

// File: rtl/bus_responder.sv
// Target end of the as_n/wr_n/stop_n/ack_n bus.
// Adds wait states, commits to the register file, pulses ack_n.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              as_n,
  input  logic              wr_n,
  input  logic              stop_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack_n,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rsp_state,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  rsp_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              ack_n_q, ack_n_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rf_rd;
  logic              commit;
  logic              rf_we;

  responder_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_rf (
    .clk  (clk),
    .we   (rf_we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(addr_q),
    .rd   (rf_rd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    ack_n_d = 1'b1;
    rdata_d = rdata_q;
    commit  = 1'b0;
    unique case (state_q)
      RSP_IDLE: begin
        if (!as_n && stop_n) begin
          addr_d  = addr;
          wdata_d = wdata;
          wr_d    = wr_n;
          cnt_d   = '0;
          state_d = RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        // abort or strobe release drops the transaction
        if (!stop_n || as_n) begin
          state_d = RSP_IDLE;
        end else if (cnt_q == WS) begin
          state_d = RSP_ACK;
          ack_n_d = 1'b0;
          commit  = 1'b1;
          if (wr_q) rdata_d = rf_rd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RSP_ACK: state_d = RSP_DONE;
      RSP_DONE: begin
        if (as_n) state_d = RSP_IDLE;
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  assign rf_we = commit && !wr_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b1;
      ack_n_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ack_n_q <= ack_n_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack_n     = ack_n_q;
  assign rdata     = rdata_q;
  assign rsp_state = state_q;
  assign busy      = (state_q != RSP_IDLE);

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder.
// Two instances: WAIT_STATES=2 (a) and WAIT_STATES=0 (b).
module tb_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       as_n, wr_n, stop_n;
  logic [3:0] addr;
  logic [7:0] wdata;

  logic       ack_a, busy_a, ack_b, busy_b;
  logic [7:0] rd_a, rd_b;
  logic [1:0] st_a, st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_responder #(.WAIT_STATES(2)) u_a (
    .clk(clk), .reset(reset), .as_n(as_n), .wr_n(wr_n),
    .stop_n(stop_n), .addr(addr), .wdata(wdata),
    .ack_n(ack_a), .rdata(rd_a), .rsp_state(st_a), .busy(busy_a)
  );

  bus_responder #(.WAIT_STATES(0)) u_b (
    .clk(clk), .reset(reset), .as_n(as_n), .wr_n(wr_n),
    .stop_n(stop_n), .addr(addr), .wdata(wdata),
    .ack_n(ack_b), .rdata(rd_b), .rsp_state(st_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic g_ack(input int sel);
    return sel != 0 ? ack_b : ack_a;
  endfunction
  function automatic logic [1:0] g_st(input int sel);
    return sel != 0 ? st_b : st_a;
  endfunction
  function automatic logic [7:0] g_rd(input int sel);
    return sel != 0 ? rd_b : rd_a;
  endfunction

  task automatic txn(input int sel, input logic wr, input logic [3:0] a,
                     input logic [7:0] d, input int exp_lat,
                     input logic chk_rd, input logic [7:0] exp_rd,
                     input int hold);
    int lat;
    int pulses;
    logic [7:0] seq;
    lat = -1;
    seq = '0;
    pulses = 0;
    as_n = 1'b0; wr_n = wr; addr = a; wdata = d; stop_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      seq = {seq[5:0], g_st(sel)};
      if (g_ack(sel) == 1'b0) begin
        lat = k - 1;
        break;
      end
      // inputs change mid-wait must not matter
      addr = ~a; wdata = ~d;
    end
    check("latency", lat, exp_lat);
    if (sel == 0) check("seq_a", seq, 8'h56);
    else check("seq_b", seq[3:0], 4'h6);
    check("ack_state", g_st(sel), 2);
    if (chk_rd) check("rdata_ack", g_rd(sel), exp_rd);
    tick();
    check("done_ack", g_ack(sel), 1);
    check("done_st", g_st(sel), 3);
    for (int h = 0; h < hold; h++) begin
      tick();
      if (g_ack(sel) == 1'b0) pulses++;
      if (g_st(sel) != 2'd3) pulses++;
    end
    if (hold > 0) check("held_strobe", pulses, 0);
    as_n = 1'b1;
    tick();
    check("release_idle", g_st(sel), 0);
    if (chk_rd) check("rdata_hold", g_rd(sel), exp_rd);
  endtask

  initial begin
    reset = 1'b1; as_n = 1'b1; wr_n = 1'b1; stop_n = 1'b1;
    addr = '0; wdata = '0;
    tick(); tick();
    check("rst_st_a", st_a, 0);
    check("rst_ack_a", ack_a, 1);
    check("rst_rd_a", rd_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_st_b", st_b, 0);
    reset = 1'b0;
    tick();

    // write then read-back
    txn(0, 1'b0, 4'd3, 8'hA5, 3, 1'b0, 8'h00, 0);
    txn(0, 1'b1, 4'd3, 8'h00, 3, 1'b1, 8'hA5, 0);

    // abort in second WAIT cycle
    txn(0, 1'b0, 4'd5, 8'h5A, 3, 1'b0, 8'h00, 0);
    as_n = 1'b0; wr_n = 1'b0; addr = 4'd5; wdata = 8'h3C;
    tick();
    check("abort_w1", st_a, 1);
    tick();
    check("abort_w2", st_a, 1);
    stop_n = 1'b0;
    tick();
    check("abort_idle", st_a, 0);
    check("abort_ack", ack_a, 1);
    tick();
    check("abort_noack", ack_a, 1);
    check("stop_idle", st_a, 0);
    as_n = 1'b1; stop_n = 1'b1;
    tick();
    txn(0, 1'b1, 4'd5, 8'h00, 3, 1'b1, 8'h5A, 0);

    // held strobe
    txn(0, 1'b0, 4'd9, 8'h77, 3, 1'b0, 8'h00, 10);
    txn(0, 1'b1, 4'd9, 8'h00, 3, 1'b1, 8'h77, 0);

    // reset mid-WAIT
    txn(0, 1'b0, 4'd7, 8'h11, 3, 1'b0, 8'h00, 0);
    as_n = 1'b0; wr_n = 1'b0; addr = 4'd7; wdata = 8'hEE;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rstw_ack", ack_a, 1);
    check("rstw_st", st_a, 0);
    check("rstw_busy", busy_a, 0);
    reset = 1'b0; as_n = 1'b1;
    tick();
    txn(0, 1'b1, 4'd7, 8'h00, 3, 1'b1, 8'h11, 0);

    // address wrap through full range
    txn(0, 1'b0, 4'hF, 8'h9E, 3, 1'b0, 8'h00, 0);
    txn(0, 1'b1, 4'hF, 8'h00, 3, 1'b1, 8'h9E, 0);

    // WAIT_STATES=0 back-to-back
    txn(1, 1'b0, 4'd2, 8'hC3, 1, 1'b0, 8'h00, 0);
    txn(1, 1'b1, 4'd2, 8'h00, 1, 1'b1, 8'hC3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
